// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 8-digit seven-segment display with a minimum hold
// time and optional preemption by requester 0. Grant, owner and disp_x are registered.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter bit          BLANK_IDLE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic        prio_en,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [31:0] disp_x,
  output logic        switch_pulse
);

  localparam logic [31:0] CNT_MAX = 32'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [1:0]       last_owner, owner_n;
  logic [31:0]      cnt, cnt_n;
  logic             sw;
  logic [3:0][31:0] data;
  logic [3:0]       owner_oh, owner_n_oh, other_req;

  assign data = {data3, data2, data1, data0};

  for (genvar i = 0; i < 4; i++) begin : g_oh
    assign owner_oh[i]   = (owner == 2'(i));
    assign owner_n_oh[i] = (owner_n == 2'(i));
  end

  assign other_req = req & ~owner_oh;

  // Round-robin search starting after last_owner; the "ex" variant skips the
  // current owner, the "all" variant is used from IDLE.
  logic       rr_all_vld, rr_ex_vld;
  logic [1:0] rr_all_idx, rr_ex_idx, cand;

  always_comb begin
    rr_all_vld = 1'b0;
    rr_all_idx = 2'd0;
    rr_ex_vld  = 1'b0;
    rr_ex_idx  = 2'd0;
    cand       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner + 2'(k);
      if (req[cand] && !rr_all_vld) begin
        rr_all_vld = 1'b1;
        rr_all_idx = cand;
      end
      if (req[cand] && (cand != owner) && !rr_ex_vld) begin
        rr_ex_vld = 1'b1;
        rr_ex_idx = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    sw      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          owner_n = rr_all_idx;
          cnt_n   = '0;
          sw      = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          // Release wins over preempt; its pick already covers requester 0.
          cnt_n = '0;
          if (rr_ex_vld) begin
            owner_n = rr_ex_idx;
            sw      = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (prio_en && req[0] && (owner != 2'd0)) begin
          owner_n = 2'd0;
          cnt_n   = '0;
          sw      = 1'b1;
        end else if ((cnt == CNT_MAX) && (|other_req)) begin
          owner_n = rr_ex_idx;
          cnt_n   = '0;
          sw      = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 2'd0;
      last_owner   <= 2'd3;
      cnt          <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      cnt          <= cnt_n;
      switch_pulse <= sw;
      busy         <= (state_n == GRANT);
      grant        <= (state_n == GRANT) ? owner_n_oh : 4'b0000;
      if (sw) last_owner <= owner_n;
    end
  end

  // Display value follows the registered owner, so it lags a switch by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_x <= '0;
    end else if (state == GRANT) begin
      disp_x <= data[owner];
    end else if (BLANK_IDLE) begin
      disp_x <= '0;
    end
  end

endmodule
